// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative RV32M multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            squash_i;
    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output squash_i, start_i, func3_i, op1_i, op2_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  squash_i, start_i, func3_i, op1_i, op2_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitudes in, unsigned shift-add / restoring-divide core,
// sign fix-up on the way out. UNROLL result bits are retired per BUSY cycle.
module ex_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_i,
    ex_muldiv_unit_if.slave bus
);
    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = $clog2(N + 1);
    localparam int W2    = 2 * XLEN;

    if (XLEN % UNROLL != 0) begin : g_unroll_check
        $error("ex_muldiv_unit: XLEN must be a multiple of UNROLL");
    end

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [W2-1:0] neg_if_w(input logic [W2-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        func3_q;
    logic              neg_q;
    logic              rneg_q;
    logic              dz_q;
    logic [XLEN-1:0]   b_q;
    logic [W2-1:0]     acc_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              last;
    logic signed [XLEN-1:0] op1_s, op2_s;
    logic              signed1, signed2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [W2-1:0]     acc_nxt;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     sum;
    logic [W2-1:0]     prod;
    logic [XLEN-1:0]   res_fin;

    assign accept = bus.start_i && !bus.squash_i && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == BUSY) && (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        if (bus.squash_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = BUSY;
                BUSY:    if (last) state_d = DONE;
                DONE:    state_d = accept ? BUSY : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand capture: MULHSU is signed only on op1; MUL's low half is sign-agnostic.
    always_comb begin
        op1_s   = bus.op1_i;
        op2_s   = bus.op2_i;
        signed1 = (bus.func3_i == F_MULH) || (bus.func3_i == F_MULHSU) ||
                  (bus.func3_i == F_DIV)  || (bus.func3_i == F_REM);
        signed2 = (bus.func3_i == F_MULH) || (bus.func3_i == F_DIV) || (bus.func3_i == F_REM);
        neg1    = signed1 && (op1_s < 0);
        neg2    = signed2 && (op2_s < 0);
        mag1    = neg_if(bus.op1_i, neg1);
        mag2    = neg_if(bus.op2_i, neg2);
    end

    // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        acc_nxt = acc_q;
        shifted = '0;
        sum     = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (func3_q[2]) begin
                shifted = {acc_nxt[W2-1:XLEN], acc_nxt[XLEN-1]};
                if (shifted >= {1'b0, b_q})
                    acc_nxt = {shifted[XLEN-1:0] - b_q, acc_nxt[XLEN-2:0], 1'b1};
                else
                    acc_nxt = {shifted[XLEN-1:0], acc_nxt[XLEN-2:0], 1'b0};
            end else begin
                sum     = {1'b0, acc_nxt[W2-1:XLEN]} + (acc_nxt[0] ? {1'b0, b_q} : '0);
                acc_nxt = {sum, acc_nxt[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod = neg_if_w(acc_nxt, neg_q);
        case (func3_q)
            F_MUL:                     res_fin = prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: res_fin = prod[W2-1:XLEN];
            F_DIV, F_DIVU:             res_fin = dz_q ? '1 : neg_if(acc_nxt[XLEN-1:0], neg_q);
            default:                   res_fin = neg_if(acc_nxt[W2-1:XLEN], rneg_q);
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= '0;
                func3_q <= bus.func3_i;
                neg_q   <= neg1 ^ neg2;
                rneg_q  <= neg1;
                dz_q    <= (bus.op2_i == '0);
                b_q     <= mag2;
                acc_q   <= {{XLEN{1'b0}}, mag1};
            end else if (state_q == BUSY && !bus.squash_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_nxt;
                if (last) result_q <= res_fin;
            end
        end
    end

    assign bus.busy_o   = (state_q == BUSY);
    assign bus.done_o   = (state_q == DONE);
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized bench for ex_muldiv_unit (UNROLL=1 and UNROLL=4 instances).
module tb_ex_muldiv_unit;
    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] last_exp = 32'd0;

    ex_muldiv_unit_if #(.XLEN(32)) bus  ();
    ex_muldiv_unit_if #(.XLEN(32)) bus4 ();

    ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut  (.clk(clk), .rst_i(rst), .bus(bus));
    ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst_i(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f)
            3'b000: p = ua * ub;
            3'b001: p = sa * sb;
            3'b010: p = sa * longint'(ub);
            3'b011: p = ua * ub;
            3'b100: if (b == 0) p = '1; else p = sa / sb;
            3'b101: if (b == 0) p = '1; else p = ua / ub;
            3'b110: if (b == 0) p = {32'd0, a}; else p = sa % sb;
            default: if (b == 0) p = {32'd0, a}; else p = ua % ub;
        endcase
        return (f == 3'b000 || f[2]) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Launches one op on both instances and checks latency, busy span, result and hold.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n, lat, lat4, busy_cnt;
        logic [31:0] res, res4, exp;
        string t;
        exp = model(f, a, b);
        t   = $sformatf("f%0d_%08h_%08h", f, a, b);
        @(negedge clk);
        bus.start_i = 1'b1;  bus.func3_i = f;  bus.op1_i = a;  bus.op2_i = b;
        bus4.start_i = 1'b1; bus4.func3_i = f; bus4.op1_i = a; bus4.op2_i = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus4.start_i = 1'b0;
        n = 1; lat = 0; lat4 = 0; busy_cnt = 0; res = '0; res4 = '0;
        while ((lat == 0 || lat4 == 0) && n <= 100) begin
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o && lat == 0) begin lat = n; res = bus.result_o; end
            if (bus4.done_o && lat4 == 0) begin lat4 = n; res4 = bus4.result_o; end
            @(negedge clk);
            n++;
        end
        check({t, "_lat"}, 32'(lat), 32'd33);
        check({t, "_busy"}, 32'(busy_cnt), 32'd32);
        check({t, "_res"}, res, exp);
        check({t, "_lat4"}, 32'(lat4), 32'd9);
        check({t, "_res4"}, res4, exp);
        check({t, "_pulse"}, 32'(bus.done_o), 32'd0);
        check({t, "_hold"}, bus.result_o, exp);
        last_exp = exp;
    endtask

    initial begin
        int n, t1, t2, pulses;
        rst = 1'b1;
        bus.squash_i = 1'b0;  bus.start_i = 1'b0;  bus.func3_i = '0;  bus.op1_i = '0;  bus.op2_i = '0;
        bus4.squash_i = 1'b0; bus4.start_i = 1'b0; bus4.func3_i = '0; bus4.op1_i = '0; bus4.op2_i = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD);
        check("mul_neg_const", last_exp, 32'hFFFF_FFEB);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op(3'b101, 32'd100, 32'd7);
        run_op(3'b111, 32'd100, 32'd7);
        run_op(3'b101, 32'd5, 32'd0);
        run_op(3'b110, 32'd5, 32'd0);
        run_op(3'b100, 32'hFFFF_FFFB, 32'd0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

        // Squash in BUSY cycle 10
        run_op(3'b101, 32'd100, 32'd7);
        @(negedge clk);
        bus.start_i = 1'b1; bus.func3_i = 3'b000; bus.op1_i = 32'd9; bus.op2_i = 32'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        bus.squash_i = 1'b1;
        @(negedge clk);
        bus.squash_i = 1'b0;
        check("squash_busy", 32'(bus.busy_o), 32'd0);
        check("squash_done", 32'(bus.done_o), 32'd0);
        check("squash_result", bus.result_o, last_exp);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) pulses++;
            @(negedge clk);
        end
        check("squash_no_pulse", 32'(pulses), 32'd0);
        run_op(3'b001, 32'h1234_5678, 32'hFEDC_BA98);

        // start and squash together from IDLE
        @(negedge clk);
        bus.start_i = 1'b1; bus.squash_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0; bus.squash_i = 1'b0;
        check("start_squash_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        check("start_squash_idle", 32'(bus.busy_o), 32'd0);

        // Async reset between edges mid-BUSY
        run_op(3'b101, 32'd100, 32'd7);
        @(negedge clk);
        bus.start_i = 1'b1; bus.func3_i = 3'b011; bus.op1_i = 32'hFFFF_FFFF; bus.op2_i = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy_o), 32'd0);
        check("async_rst_done", 32'(bus.done_o), 32'd0);
        check("async_rst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: start held through BUSY and DONE
        @(negedge clk);
        bus.start_i = 1'b1; bus.func3_i = 3'b000; bus.op1_i = 32'd3; bus.op2_i = 32'd5;
        @(negedge clk);
        bus.func3_i = 3'b101; bus.op1_i = 32'd1000; bus.op2_i = 32'd10;
        n = 1; t1 = 0; t2 = 0;
        while (t2 == 0 && n < 200) begin
            if (bus.done_o) begin
                if (t1 == 0) begin
                    t1 = n;
                    check("b2b_first_res", bus.result_o, 32'd15);
                end else begin
                    t2 = n;
                    check("b2b_second_res", bus.result_o, 32'd100);
                    bus.start_i = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        bus.start_i = 1'b0;
        check("b2b_first_lat", 32'(t1), 32'd33);
        check("b2b_spacing", 32'(t2 - t1), 32'd33);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
